fifo_pkt_writer: RTL and testbench

- Write-side producer for the team's dual-clock FIFO. Lives entirely in the wr_clk domain and drives the FIFO write port (wr_en, wdata, full).
- Frames an upstream byte stream into packets: one header byte (the length), N payload bytes, then one XOR checksum byte.
- Throttles itself on the FIFO full flag, so the FIFO never sees a write while full. The FIFO overflow flag must never assert.

---
 rtl/fifo_pkt_writer.sv | 109 ++++++++++
 tb/tb_fifo_pkt_writer.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_writer.sv
// Write-side packet framer for the dual-clock FIFO: emits header (length), payload, XOR checksum.
// Writes are gated combinationally on fifo_full so the FIFO is never written while full.
module fifo_pkt_writer #(
  parameter int data_width = 8,
  parameter int len_width  = 4,
  parameter int cnt_width  = 16
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [len_width-1:0]  pkt_len,
  input  logic [data_width-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [data_width-1:0] fifo_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  output logic [cnt_width-1:0]  pkt_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HDR     = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
  localparam logic [1:0] CSUM    = 2'd3;

  logic [1:0]            state;
  logic [len_width-1:0]  remaining;
  logic [data_width-1:0] csum;
  logic                  last_byte;

  assign last_byte = (remaining == len_width'(1));
  assign busy      = (state != IDLE);

  // No register stage on the write strobe: it always reflects the current full flag.
  always_comb begin
    fifo_wr_en = 1'b0;
    s_ready    = 1'b0;
    fifo_wdata = '0;
    case (state)
      HDR: begin
        fifo_wdata = data_width'(remaining);
        fifo_wr_en = !fifo_full;
      end
      PAYLOAD: begin
        fifo_wdata = s_data;
        s_ready    = !fifo_full;
        fifo_wr_en = s_valid && !fifo_full;
      end
      CSUM: begin
        fifo_wdata = csum;
        fifo_wr_en = !fifo_full;
      end
      default: ;
    endcase
    if (rst) begin
      fifo_wr_en = 1'b0;
      s_ready    = 1'b0;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      csum      <= '0;
      pkt_count <= '0;
      done      <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      len_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (pkt_len != '0) begin
              remaining <= pkt_len;
              csum      <= data_width'(pkt_len);
              state     <= HDR;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        HDR: begin
          if (fifo_wr_en) state <= PAYLOAD;
        end
        PAYLOAD: begin
          if (fifo_wr_en) begin
            csum      <= csum ^ s_data;
            remaining <= remaining - len_width'(1);
            if (last_byte) state <= CSUM;
          end
        end
        CSUM: begin
          if (fifo_wr_en) begin
            state     <= IDLE;
            pkt_count <= pkt_count + cnt_width'(1);
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Directed bench for fifo_pkt_writer: framing, stalls, reset, counter wrap and a behavioural dual-clock FIFO.
module tb_fifo_pkt_writer;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int CW = 4;
  localparam int DEPTH = 16;

  logic          wr_clk = 1'b0;
  logic          rd_clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] pkt_len = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wdata;
  logic          busy;
  logic          done;
  logic          len_err;
  logic [CW-1:0] pkt_count;

  logic tb_full = 1'b0;
  logic model_full = 1'b0;
  logic use_fifo = 1'b0;
  logic overflow = 1'b0;

  logic [7:0] src_q[$];
  logic [7:0] wr_log[$];
  logic [7:0] rd_log[$];
  logic [7:0] mq[$];
  int         wr_cyc[$];
  int         src_mode = 0;
  int         tcnt = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         lerr_cnt = 0;

  int checks = 0;
  int errors = 0;

  assign fifo_full = use_fifo ? model_full : tb_full;

  fifo_pkt_writer #(.data_width(DW), .len_width(LW), .cnt_width(CW)) dut (
    .wr_clk(wr_clk), .rst(rst), .start(start), .pkt_len(pkt_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata),
    .busy(busy), .done(done), .len_err(len_err), .pkt_count(pkt_count)
  );

  always #5 wr_clk = ~wr_clk;

  // Read clock is 3x slower and phase-shifted so its edges never coincide with wr_clk edges.
  initial begin
    #2;
    forever #15 rd_clk = ~rd_clk;
  end

  always @(posedge wr_clk) begin
    if (s_valid && s_ready && src_q.size() > 0) void'(src_q.pop_front());
    tcnt++;
    #1;
    if (src_q.size() == 0) begin
      s_valid = 1'b0;
      s_data  = '0;
    end else begin
      s_data = src_q[0];
      case (src_mode)
        1:       s_valid = tcnt[0];
        2:       s_valid = ($urandom_range(0, 3) != 0);
        default: s_valid = 1'b1;
      endcase
    end
  end

  always @(negedge wr_clk) begin
    cyc++;
    if (fifo_wr_en) begin
      wr_log.push_back(fifo_wdata);
      wr_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (len_err) lerr_cnt++;
  end

  always @(posedge wr_clk) begin
    if (use_fifo && fifo_wr_en) begin
      if (mq.size() >= DEPTH) overflow = 1'b1;
      else mq.push_back(fifo_wdata);
      model_full = (mq.size() >= DEPTH);
    end
  end

  always @(posedge rd_clk) begin
    if (use_fifo && mq.size() > 0) begin
      rd_log.push_back(mq.pop_front());
      model_full = (mq.size() >= DEPTH);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cycle();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic start_pkt(input logic [LW-1:0] len);
    cycle();
    start   = 1'b1;
    pkt_len = len;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    ok = (done_cnt >= target);
  endtask

  task automatic wait_writes(input int target, input int budget, output bit ok);
    int n = 0;
    while (wr_log.size() < target && n < budget) begin
      cycle();
      n++;
    end
    ok = (wr_log.size() >= target);
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start   = 1'b1;
    pkt_len = 4'd5;
    repeat (3) cycle();
    @(negedge wr_clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (len_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_len_err: got %b expected 0", len_err); end
    checks++;
    if (pkt_count !== '0) begin errors++; $display("[TB] FAIL reset_pkt_count: got %0d expected 0", pkt_count); end
    checks++;
    if (fifo_wr_en !== 1'b0 || s_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_strobes: got wr_en=%b s_ready=%b expected 0/0", fifo_wr_en, s_ready);
    end
    cycle();
    start = 1'b0;
    rst   = 1'b0;
    @(negedge wr_clk);
    checks++;
    if (busy !== 1'b0 || fifo_wdata !== '0) begin
      errors++; $display("[TB] FAIL reset_idle: got busy=%b wdata=%h expected 0/00", busy, fifo_wdata);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_v[5] = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    bit ok;
    int d;
    wr_log.delete();
    wr_cyc.delete();
    src_mode = 0;
    src_q = '{8'h11, 8'h22, 8'h33};
    d = done_cnt;
    start_pkt(4'd3);
    wait_done(d + 1, 40, ok);
    cycle();
    cycle();
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL basic_timeout: got no done, expected done within 40 cycles"); end
    checks++;
    if (wr_log.size() != 5) begin
      errors++; $display("[TB] FAIL basic_count: got %0d writes expected 5", wr_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wr_log[i] !== exp_v[i]) begin
          errors++; $display("[TB] FAIL basic_word%0d: got %h expected %h", i, wr_log[i], exp_v[i]);
        end
      end
      checks++;
      if (wr_cyc[4] - wr_cyc[0] != 4) begin
        errors++; $display("[TB] FAIL basic_span: got %0d cycles expected 4", wr_cyc[4] - wr_cyc[0]);
      end
    end
    checks++;
    if (done_cnt != d + 1) begin errors++; $display("[TB] FAIL basic_done: got %0d pulses expected 1", done_cnt - d); end
    checks++;
    if (pkt_count !== 4'd1) begin errors++; $display("[TB] FAIL basic_pkt_count: got %0d expected 1", pkt_count); end
  endtask

  task automatic test_len_zero();
    int w = wr_log.size();
    int l = lerr_cnt;
    cycle();
    start   = 1'b1;
    pkt_len = 4'd0;
    cycle();
    start = 1'b0;
    @(negedge wr_clk);
    checks++;
    if (len_err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL len0_pulse: got len_err=%b busy=%b expected 1/0", len_err, busy);
    end
    cycle();
    @(negedge wr_clk);
    checks++;
    if (len_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL len0_after: got len_err=%b busy=%b expected 0/0", len_err, busy);
    end
    checks++;
    if (lerr_cnt != l + 1) begin errors++; $display("[TB] FAIL len0_count: got %0d pulses expected 1", lerr_cnt - l); end
    checks++;
    if (wr_log.size() != w) begin errors++; $display("[TB] FAIL len0_writes: got %0d writes expected 0", wr_log.size() - w); end
    checks++;
    if (pkt_count !== 4'd1) begin errors++; $display("[TB] FAIL len0_pkt_count: got %0d expected 1", pkt_count); end
  endtask

  task automatic test_stall();
    logic [7:0] exp_v[6] = '{8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h44};
    bit ok;
    int d;
    wr_log.delete();
    wr_cyc.delete();
    src_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    d = done_cnt;
    start_pkt(4'd4);
    wait_writes(3, 20, ok);
    tb_full = 1'b1;
    checks++;
    if (!ok || wr_log.size() != 3) begin
      errors++; $display("[TB] FAIL stall_pre: got %0d writes expected 3", wr_log.size());
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge wr_clk);
      checks++;
      if (fifo_wr_en !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got wr_en=%b s_ready=%b busy=%b expected 0/0/1", i, fifo_wr_en, s_ready, busy);
      end
      cycle();
    end
    tb_full = 1'b0;
    wait_done(d + 1, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL stall_timeout: got no done, expected done within 30 cycles"); end
    checks++;
    if (wr_log.size() != 6) begin
      errors++; $display("[TB] FAIL stall_count: got %0d writes expected 6", wr_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wr_log[i] !== exp_v[i]) begin
          errors++; $display("[TB] FAIL stall_word%0d: got %h expected %h", i, wr_log[i], exp_v[i]);
        end
      end
      checks++;
      if (wr_cyc[3] - wr_cyc[2] != 6 || wr_cyc[5] - wr_cyc[3] != 2) begin
        errors++;
        $display("[TB] FAIL stall_resume: got gaps %0d/%0d expected 6/2", wr_cyc[3] - wr_cyc[2], wr_cyc[5] - wr_cyc[3]);
      end
    end
  endtask

  task automatic test_valid_toggle();
    bit ok;
    int d;
    wr_log.delete();
    wr_cyc.delete();
    src_mode = 1;
    for (int i = 1; i <= 15; i++) src_q.push_back(8'(i));
    d = done_cnt;
    start_pkt(4'd15);
    wait_done(d + 1, 100, ok);
    src_mode = 0;
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL toggle_timeout: got no done, expected done within 100 cycles"); end
    checks++;
    if (wr_log.size() != 17) begin
      errors++; $display("[TB] FAIL toggle_count: got %0d writes expected 17", wr_log.size());
    end else begin
      checks++;
      if (wr_log[0] !== 8'h0F) begin errors++; $display("[TB] FAIL toggle_header: got %h expected 0f", wr_log[0]); end
      for (int i = 1; i <= 15; i++) begin
        checks++;
        if (wr_log[i] !== 8'(i)) begin
          errors++; $display("[TB] FAIL toggle_byte%0d: got %h expected %h", i, wr_log[i], 8'(i));
        end
      end
      checks++;
      if (wr_log[16] !== 8'h0F) begin errors++; $display("[TB] FAIL toggle_csum: got %h expected 0f", wr_log[16]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d;
    wr_log.delete();
    src_q = '{8'h55, 8'h66, 8'h77};
    start_pkt(4'd3);
    wait_writes(2, 20, ok);
    rst = 1'b1;
    @(negedge wr_clk);
    checks++;
    if (!ok || fifo_wr_en !== 1'b0 || s_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_gate: got wr_en=%b s_ready=%b expected 0/0", fifo_wr_en, s_ready);
    end
    cycle();
    rst = 1'b0;
    src_q.delete();
    wr_log.delete();
    @(negedge wr_clk);
    checks++;
    if (busy !== 1'b0 || pkt_count !== '0) begin
      errors++; $display("[TB] FAIL rstmid_state: got busy=%b pkt_count=%0d expected 0/0", busy, pkt_count);
    end
    src_q = '{8'hA5};
    d = done_cnt;
    start_pkt(4'd1);
    wait_done(d + 1, 20, ok);
    checks++;
    if (!ok || wr_log.size() != 3) begin
      errors++; $display("[TB] FAIL rstmid_count: got %0d writes expected 3", wr_log.size());
    end else begin
      checks++;
      if (wr_log[0] !== 8'h01 || wr_log[1] !== 8'hA5 || wr_log[2] !== 8'hA4) begin
        errors++;
        $display("[TB] FAIL rstmid_words: got %h %h %h expected 01 a5 a4", wr_log[0], wr_log[1], wr_log[2]);
      end
    end
    checks++;
    if (pkt_count !== 4'd1) begin errors++; $display("[TB] FAIL rstmid_pkt_count: got %0d expected 1", pkt_count); end
  endtask

  task automatic test_count_wrap();
    bit ok;
    bit all_ok = 1'b1;
    int d;
    for (int i = 0; i < 14; i++) begin
      src_q.push_back(8'(i));
      d = done_cnt;
      start_pkt(4'd1);
      wait_done(d + 1, 20, ok);
      all_ok &= ok;
    end
    checks++;
    if (!all_ok || pkt_count !== 4'd15) begin
      errors++; $display("[TB] FAIL wrap_max: got %0d (ok=%b) expected 15", pkt_count, all_ok);
    end
    src_q.push_back(8'h99);
    d = done_cnt;
    start_pkt(4'd1);
    wait_done(d + 1, 20, ok);
    checks++;
    if (!ok || pkt_count !== 4'd0) begin
      errors++; $display("[TB] FAIL wrap_zero: got %0d (ok=%b) expected 0", pkt_count, ok);
    end
  endtask

  task automatic test_fifo();
    logic [7:0] exp_q[$];
    logic [LW-1:0] len;
    logic [7:0] b;
    logic [7:0] cs;
    bit ok;
    bit all_ok = 1'b1;
    int d;
    int n = 0;
    int bad = -1;
    mq.delete();
    rd_log.delete();
    use_fifo = 1'b1;
    src_mode = 2;
    for (int p = 0; p < 10; p++) begin
      len = LW'($urandom_range(1, 15));
      cs  = 8'(len);
      exp_q.push_back(8'(len));
      for (int i = 0; i < int'(len); i++) begin
        b = 8'($urandom);
        cs ^= b;
        exp_q.push_back(b);
        src_q.push_back(b);
      end
      exp_q.push_back(cs);
      d = done_cnt;
      start_pkt(len);
      wait_done(d + 1, 400, ok);
      all_ok &= ok;
    end
    while (mq.size() > 0 && n < 200) begin
      cycle();
      n++;
    end
    repeat (6) cycle();
    src_mode = 0;
    checks++;
    if (!all_ok || rd_log.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL fifo_len: got %0d words (ok=%b) expected %0d", rd_log.size(), all_ok, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && rd_log[i] !== exp_q[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++; $display("[TB] FAIL fifo_stream: word %0d got %h expected %h", bad, rd_log[bad], exp_q[bad]);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fifo_overflow: got %b expected 0", overflow); end
    use_fifo = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_stall();
    test_valid_toggle();
    test_reset_mid();
    test_count_wrap();
    test_fifo();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
